// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arb_pkg;

    // Default line address width (byte address bits 31:4) and line width.
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_LINE_W = 128;

    // Owner encoding, also used as the round-robin "last owner" value.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins. On a tie, the side that did not own the
// previous transaction wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       rr_last,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    // Choose the winner index, then expand it to a one-hot grant.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        winner_o = OWN_I;
        grant_o  = 2'b00;
        if (req_i && req_d) begin
            winner_o = ~rr_last;
        end else if (req_d) begin
            winner_o = OWN_D;
        end
        if (req_i || req_d) begin
            grant_o[winner_o] = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Arbiter sharing one line-granular memory port between the I-cache and D-cache.
// It latches one requester's transaction and holds it stable until memory
// answers. It then returns the single-cycle ready to the owner and spends one
// quiet cycle before arbitrating again.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [LINE_W-1:0] mem_wdata_I,
    output logic [LINE_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,
    // D-cache side
    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [LINE_W-1:0] mem_wdata_D,
    output logic [LINE_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,
    // Downstream memory
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_last_q, rr_last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              req_i;
    logic              req_d;
    logic [1:0]        grant;
    logic              winner;

    // A side is requesting when either strobe is high; both high means write.
    assign req_i = mem_read_I | mem_write_I;
    assign req_d = mem_read_D | mem_write_D;

    rr_arb2 u_rr_arb2 (
        .req_i    (req_i),
        .req_d    (req_d),
        .rr_last  (rr_last_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Next-state logic: grant in IDLE, hold in BUSY, one quiet cycle in RELEASE.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    owner_d   = winner;
                    rr_last_d = winner;
                    state_d   = BUSY;
                    if (grant[OWN_D]) begin
                        mem_write_d = mem_write_D;
                        mem_read_d  = mem_read_D & ~mem_write_D;
                        mem_addr_d  = mem_addr_D;
                        mem_wdata_d = mem_wdata_D;
                    end else begin
                        mem_write_d = mem_write_I;
                        mem_read_d  = mem_read_I & ~mem_write_I;
                        mem_addr_d  = mem_addr_I;
                        mem_wdata_d = mem_wdata_I;
                    end
                end
            end
            BUSY: begin
                // Requester inputs are deliberately ignored until memory answers.
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // Lets the previous owner drop its strobes before re-arbitration.
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State, ownership and downstream registers; cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            rr_last_q   <= OWN_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Ready demux: only the current owner sees memory's completion, and only in BUSY.
    always_comb begin
        mem_ready_I = 1'b0;
        mem_ready_D = 1'b0;
        if ((state_q == BUSY) && mem_ready) begin
            if (owner_q == OWN_D) begin
                mem_ready_D = 1'b1;
            end else begin
                mem_ready_I = 1'b1;
            end
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;

endmodule : mem_arbiter
